// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Opcode constants (IR[31:27]), ALU operation codes, FSM state encoding and
// the control-vector struct driven toward the datapath.
// ALU codes reuse the matching opcode values, so register-register and
// mul/div instructions pass IR_op straight through as ALU_select.
// The STEP_WAIT state is only reachable when SINGLE_STEP_EN is defined.
package cpu_ctrl_pkg;

  localparam int OPW  = 5;  // opcode field width
  localparam int ALUW = 5;  // ALU_select width

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD = 5'b00011;
  localparam logic [ALUW-1:0] ALU_SUB = 5'b00100;
  localparam logic [ALUW-1:0] ALU_AND = 5'b00101;
  localparam logic [ALUW-1:0] ALU_OR  = 5'b00110;
  localparam logic [ALUW-1:0] ALU_SHR = 5'b00111;
  localparam logic [ALUW-1:0] ALU_SHL = 5'b01000;
  localparam logic [ALUW-1:0] ALU_ROR = 5'b01001;
  localparam logic [ALUW-1:0] ALU_ROL = 5'b01010;
  localparam logic [ALUW-1:0] ALU_MUL = 5'b01110;
  localparam logic [ALUW-1:0] ALU_DIV = 5'b01111;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2,
    S_T3, S_T4, S_T5, S_T6, S_T7,
    S_HALT, S_STEP_WAIT
  } state_t;

  typedef struct packed {
    logic            PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
    logic            PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin;
    logic            Gra, Grb, Grc, Rin, Rout;
    logic            IncPC, Read, Write;
    logic [ALUW-1:0] ALU_select;
    logic            Run, illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op <= OP_DIV) || (op == OP_BR) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  // Final execute state of an instruction; FETCH2 means nothing to execute.
  function automatic state_t last_step(input logic [OPW-1:0] op);
    if (((op >= OP_ADD) && (op <= OP_ORI)) || (op == OP_LDI)) return S_T5;
    if ((op == OP_MUL) || (op == OP_DIV) || (op == OP_BR))    return S_T6;
    if ((op == OP_LD) || (op == OP_ST))                       return S_T7;
    return S_FETCH2;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the datapath.
// master: sequencer (reads IR_op/CON_FF/mem_ready, drives all controls).
// slave : datapath side (drives IR_op/CON_FF/mem_ready, reads controls).
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [OPW-1:0]  IR_op;
  logic            CON_FF, mem_ready;
  logic            PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
  logic            PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin;
  logic            Gra, Grb, Grc, Rin, Rout;
  logic            IncPC, Read, Write;
  logic [ALUW-1:0] ALU_select;
  logic            Run, illegal_op;

  modport master (
    input  IR_op, CON_FF, mem_ready,
    output PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
           PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin,
           Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write,
           ALU_select, Run, illegal_op
  );

  modport slave (
    output IR_op, CON_FF, mem_ready,
    input  PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
           PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin,
           Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write,
           ALU_select, Run, illegal_op
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of sequencer state (+ IR_op, CON_FF) into the
// datapath control vector.
// Ports: i_state  current FSM state
//        i_op     IR[31:27]
//        i_con_ff branch condition, gates PCin in the branch T6 step
//        o_ctrl   full control vector
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t         i_state,
  input  logic [OPW-1:0] i_op,
  input  logic           i_con_ff,
  output ctrl_t          o_ctrl
);

  logic w_rr, w_imm, w_md, w_ld, w_ldi, w_st, w_mem, w_br;
  logic [ALUW-1:0] w_imm_alu;

  assign w_rr   = (i_op >= OP_ADD) && (i_op <= OP_ROL);
  assign w_imm  = (i_op >= OP_ADDI) && (i_op <= OP_ORI);
  assign w_md   = (i_op == OP_MUL) || (i_op == OP_DIV);
  assign w_ld   = (i_op == OP_LD);
  assign w_ldi  = (i_op == OP_LDI);
  assign w_st   = (i_op == OP_ST);
  assign w_mem  = w_ld || w_ldi || w_st;  // share the base+offset address steps
  assign w_br   = (i_op == OP_BR);
  assign w_imm_alu = (i_op == OP_ADDI) ? ALU_ADD :
                     (i_op == OP_ANDI) ? ALU_AND : ALU_OR;

  always_comb begin
    o_ctrl     = '0;
    o_ctrl.Run = 1'b1;
    case (i_state)
      S_FETCH0: begin
        o_ctrl.PCout = 1'b1; o_ctrl.MARin = 1'b1; o_ctrl.IncPC = 1'b1; o_ctrl.Zin = 1'b1;
      end
      S_FETCH1: begin
        o_ctrl.Zlowout = 1'b1; o_ctrl.PCin = 1'b1; o_ctrl.Read = 1'b1; o_ctrl.MDRin = 1'b1;
      end
      S_FETCH2: begin
        o_ctrl.MDRout     = 1'b1; o_ctrl.IRin = 1'b1;
        o_ctrl.illegal_op = ~op_legal(i_op);
      end
      S_T3: begin
        if (w_md) begin
          o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Yin = 1'b1;
        end else if (w_br) begin
          o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.CONin = 1'b1;
        end else if (w_mem) begin
          o_ctrl.Grb = 1'b1; o_ctrl.BAout = 1'b1; o_ctrl.Yin = 1'b1;
        end else begin
          o_ctrl.Grb = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Yin = 1'b1;
        end
      end
      S_T4: begin
        if (w_rr || w_md) begin
          // ALU codes equal opcodes for these classes
          o_ctrl.Grc = w_rr; o_ctrl.Grb = w_md;
          o_ctrl.Rout = 1'b1; o_ctrl.Zin = 1'b1; o_ctrl.ALU_select = i_op;
        end else if (w_imm) begin
          o_ctrl.Cout = 1'b1; o_ctrl.Zin = 1'b1; o_ctrl.ALU_select = w_imm_alu;
        end else if (w_mem) begin
          o_ctrl.Cout = 1'b1; o_ctrl.Zin = 1'b1; o_ctrl.ALU_select = ALU_ADD;
        end else if (w_br) begin
          o_ctrl.PCout = 1'b1; o_ctrl.Yin = 1'b1;
        end
      end
      S_T5: begin
        if (w_rr || w_imm || w_ldi) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1;
        end else if (w_md) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.LOin = 1'b1;
        end else if (w_ld || w_st) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.MARin = 1'b1;
        end else if (w_br) begin
          o_ctrl.Cout = 1'b1; o_ctrl.Zin = 1'b1; o_ctrl.ALU_select = ALU_ADD;
        end
      end
      S_T6: begin
        if (w_md) begin
          o_ctrl.Zhighout = 1'b1; o_ctrl.HIin = 1'b1;
        end else if (w_ld) begin
          o_ctrl.Read = 1'b1; o_ctrl.MDRin = 1'b1;
        end else if (w_st) begin
          o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.MDRin = 1'b1;
        end else if (w_br) begin
          o_ctrl.Zlowout = 1'b1; o_ctrl.PCin = i_con_ff;
        end
      end
      S_T7: begin
        if (w_ld) begin
          o_ctrl.MDRout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1;
        end else if (w_st) begin
          o_ctrl.Write = 1'b1;
        end
      end
      S_HALT, S_STEP_WAIT: o_ctrl.Run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (FETCH0..2), decode IR_op, execute T3..T7.
// Ports: Clock  rising-edge clock
//        clr    synchronous active-high reset to FETCH0
//        step   (SINGLE_STEP_EN only) advance one instruction per rising edge
//        bus    control_sequencer_if.master: IR_op/CON_FF/mem_ready in,
//               all datapath enables/selects, ALU_select, Run, illegal_op out
// Macro SINGLE_STEP_EN: park in STEP_WAIT after every instruction.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic Clock,
  input logic clr,
`ifdef SINGLE_STEP_EN
  input logic step,
`endif
  control_sequencer_if.master bus
);

  state_t r_state, w_next, w_last;
  ctrl_t  w_ctrl, w_out;
  logic   w_stall, w_step_go;

`ifdef SINGLE_STEP_EN
  localparam state_t END_STATE = S_STEP_WAIT;
  logic r_step_q;
  always_ff @(posedge Clock) begin
    if (clr) r_step_q <= 1'b0;
    else     r_step_q <= step;
  end
  assign w_step_go = step & ~r_step_q;  // rising edge: a held step is one request
`else
  localparam state_t END_STATE = S_FETCH0;
  assign w_step_go = 1'b1;
`endif

  ctrl_decode u_dec (
    .i_state  (r_state),
    .i_op     (bus.IR_op),
    .i_con_ff (bus.CON_FF),
    .o_ctrl   (w_ctrl)
  );

  assign w_last  = last_step(bus.IR_op);
  // Any state strobing memory holds until the memory completes.
  assign w_stall = (w_ctrl.Read | w_ctrl.Write) & ~bus.mem_ready;

  always_ff @(posedge Clock) begin
    if (clr) r_state <= S_FETCH0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH0: w_next = S_FETCH1;
      S_FETCH1: if (!w_stall) w_next = S_FETCH2;
      S_FETCH2: begin
        if (bus.IR_op == OP_HALT)     w_next = S_HALT;
        else if (w_last == S_FETCH2)  w_next = END_STATE;  // nop / undefined
        else                          w_next = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (w_stall)               w_next = r_state;
        else if (r_state == w_last) w_next = END_STATE;
        else begin
          case (r_state)
            S_T3:    w_next = S_T4;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = S_T6;
            default: w_next = S_T7;
          endcase
        end
      end
      S_HALT:      w_next = S_HALT;
      S_STEP_WAIT: if (w_step_go) w_next = S_FETCH0;
      default:     w_next = S_FETCH0;
    endcase
  end

  // Reset masks every strobe but keeps Run high.
  always_comb begin
    w_out = w_ctrl;
    if (clr) begin
      w_out     = '0;
      w_out.Run = 1'b1;
    end
  end

  assign bus.PCout      = w_out.PCout;
  assign bus.Zlowout    = w_out.Zlowout;
  assign bus.Zhighout   = w_out.Zhighout;
  assign bus.MDRout     = w_out.MDRout;
  assign bus.Cout       = w_out.Cout;
  assign bus.BAout      = w_out.BAout;
  assign bus.PCin       = w_out.PCin;
  assign bus.IRin       = w_out.IRin;
  assign bus.Yin        = w_out.Yin;
  assign bus.Zin        = w_out.Zin;
  assign bus.MARin      = w_out.MARin;
  assign bus.MDRin      = w_out.MDRin;
  assign bus.HIin       = w_out.HIin;
  assign bus.LOin       = w_out.LOin;
  assign bus.CONin      = w_out.CONin;
  assign bus.Gra        = w_out.Gra;
  assign bus.Grb        = w_out.Grb;
  assign bus.Grc        = w_out.Grc;
  assign bus.Rin        = w_out.Rin;
  assign bus.Rout       = w_out.Rout;
  assign bus.IncPC      = w_out.IncPC;
  assign bus.Read       = w_out.Read;
  assign bus.Write      = w_out.Write;
  assign bus.ALU_select = w_out.ALU_select;
  assign bus.Run        = w_out.Run;
  assign bus.illegal_op = w_out.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: builds a per-cycle plan (inputs + expected
// control vector) from instruction-level step lists, then drives and checks
// the DUT once per cycle, plus literal spot checks on key cycles.
module tb_control_sequencer;

  localparam logic [4:0] B_LD = 5'd0, B_LDI = 5'd1, B_ST = 5'd2, B_ADD = 5'd3,
    B_SUB = 5'd4, B_AND = 5'd5, B_OR = 5'd6, B_SHR = 5'd7, B_SHL = 5'd8,
    B_ROR = 5'd9, B_ROL = 5'd10, B_ADDI = 5'd11, B_ANDI = 5'd12, B_ORI = 5'd13,
    B_MUL = 5'd14, B_DIV = 5'd15, B_BR = 5'd18, B_NOP = 5'd26, B_HALT = 5'd27;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
    logic PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
    logic [4:0] alu;
    logic run, ill;
  } ov_t;

  typedef struct {
    logic       clr;
    logic [4:0] op;
    logic       con;
    logic       mr;
    ov_t        e;
    int         pin;
  } cyc_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
`ifdef SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  always #5 clk = ~clk;

  control_sequencer_if bus();

  control_sequencer dut (
    .Clock (clk),
    .clr   (clr),
`ifdef SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  cyc_t       plan[$];
  logic [4:0] cur_op  = 5'd0;
  logic       cur_con = 1'b0;
  int         budget  = -1;
  int         checks  = 0;
  int         failures = 0;

  function automatic ov_t idle();
    ov_t v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  function automatic logic legal(input logic [4:0] op);
    return (op <= 5'd15) || (op == B_BR) || (op == B_NOP) || (op == B_HALT);
  endfunction

  task automatic push(input ov_t e, input logic mr);
    cyc_t c;
    if (budget == 0) return;
    if (budget > 0) budget--;
    c.clr = 1'b0; c.op = cur_op; c.con = cur_con; c.mr = mr; c.e = e; c.pin = 0;
    plan.push_back(c);
  endtask

  task automatic clr_cycles(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c.clr = 1'b1; c.op = cur_op; c.con = cur_con; c.mr = 1'b1; c.e = idle(); c.pin = 0;
      plan.push_back(c);
    end
  endtask

  task automatic halt_cycles(input int n);
    ov_t v = '0;  // everything low, Run low
    for (int k = 0; k < n; k++) push(v, 1'b1);
  endtask

  task automatic wb_reg();
    ov_t v = idle();
    v.Zlowout = 1; v.Gra = 1; v.Rin = 1; push(v, 1'b1);
  endtask

  // Step list of one instruction; fwait/mwait = memory-busy cycles in fetch / data access.
  task automatic instr(input logic [4:0] op, input logic con, input int fwait, input int mwait);
    ov_t v;
    cur_op = op; cur_con = con;
    v = idle(); v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; push(v, 1'b1);
    v = idle(); v.Zlowout = 1; v.PCin = 1; v.Read = 1; v.MDRin = 1;
    for (int k = 0; k < fwait; k++) push(v, 1'b0);
    push(v, 1'b1);
    v = idle(); v.MDRout = 1; v.IRin = 1; v.ill = !legal(op); push(v, 1'b1);
    if (op >= B_ADD && op <= B_ORI) begin
      v = idle(); v.Grb = 1; v.Rout = 1; v.Yin = 1; push(v, 1'b1);
      v = idle(); v.Zin = 1;
      if (op <= B_ROL) begin v.Grc = 1; v.Rout = 1; v.alu = op; end
      else begin
        v.Cout = 1;
        v.alu = (op == B_ADDI) ? 5'b00011 : (op == B_ANDI) ? 5'b00101 : 5'b00110;
      end
      push(v, 1'b1);
      wb_reg();
    end else if (op == B_MUL || op == B_DIV) begin
      v = idle(); v.Gra = 1; v.Rout = 1; v.Yin = 1; push(v, 1'b1);
      v = idle(); v.Grb = 1; v.Rout = 1; v.Zin = 1; v.alu = op; push(v, 1'b1);
      v = idle(); v.Zlowout = 1; v.LOin = 1; push(v, 1'b1);
      v = idle(); v.Zhighout = 1; v.HIin = 1; push(v, 1'b1);
    end else if (op == B_LD || op == B_LDI || op == B_ST) begin
      v = idle(); v.Grb = 1; v.BAout = 1; v.Yin = 1; push(v, 1'b1);
      v = idle(); v.Cout = 1; v.Zin = 1; v.alu = 5'b00011; push(v, 1'b1);
      if (op == B_LDI) wb_reg();
      else begin
        v = idle(); v.Zlowout = 1; v.MARin = 1; push(v, 1'b1);
        if (op == B_LD) begin
          v = idle(); v.Read = 1; v.MDRin = 1;
          for (int k = 0; k < mwait; k++) push(v, 1'b0);
          push(v, 1'b1);
          v = idle(); v.MDRout = 1; v.Gra = 1; v.Rin = 1; push(v, 1'b1);
        end else begin
          v = idle(); v.Gra = 1; v.Rout = 1; v.MDRin = 1; push(v, 1'b1);
          v = idle(); v.Write = 1;
          for (int k = 0; k < mwait; k++) push(v, 1'b0);
          push(v, 1'b1);
        end
      end
    end else if (op == B_BR) begin
      v = idle(); v.Gra = 1; v.Rout = 1; v.CONin = 1; push(v, 1'b1);
      v = idle(); v.PCout = 1; v.Yin = 1; push(v, 1'b1);
      v = idle(); v.Cout = 1; v.Zin = 1; v.alu = 5'b00011; push(v, 1'b1);
      v = idle(); v.Zlowout = 1; v.PCin = con; push(v, 1'b1);
    end
    // nop, halt and undefined opcodes have no execute steps
  endtask

  function automatic ov_t dut_vec();
    ov_t v;
    v.PCout = bus.PCout; v.Zlowout = bus.Zlowout; v.Zhighout = bus.Zhighout;
    v.MDRout = bus.MDRout; v.Cout = bus.Cout; v.BAout = bus.BAout;
    v.PCin = bus.PCin; v.IRin = bus.IRin; v.Yin = bus.Yin; v.Zin = bus.Zin;
    v.MARin = bus.MARin; v.MDRin = bus.MDRin; v.HIin = bus.HIin; v.LOin = bus.LOin;
    v.CONin = bus.CONin; v.Gra = bus.Gra; v.Grb = bus.Grb; v.Grc = bus.Grc;
    v.Rin = bus.Rin; v.Rout = bus.Rout; v.IncPC = bus.IncPC; v.Read = bus.Read;
    v.Write = bus.Write; v.alu = bus.ALU_select; v.run = bus.Run; v.ill = bus.illegal_op;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, idx, g, e);
    end
  endtask

  initial begin
    int s, s2, srcs, rd_run, last_run;
    ov_t got;
    bus.IR_op = 5'd0; bus.CON_FF = 1'b0; bus.mem_ready = 1'b1;
    rd_run = 0; last_run = 0;

    clr_cycles(2); plan[1].pin = 10;
    s = plan.size(); instr(B_AND, 0, 0, 0); plan[s + 4].pin = 1;
    instr(B_ADD, 0, 1, 0); plan[s + 6].pin = 2;
    instr(B_SUB, 0, 0, 0); instr(B_OR, 0, 0, 0); instr(B_SHR, 0, 0, 0);
    instr(B_SHL, 0, 0, 0); instr(B_ROR, 0, 0, 0); instr(B_ROL, 0, 0, 0);
    instr(B_ADDI, 0, 0, 0); instr(B_ANDI, 0, 0, 0); instr(B_ORI, 0, 2, 0);
    instr(B_MUL, 0, 0, 0); instr(B_DIV, 0, 0, 0);
    s = plan.size(); instr(B_LD, 0, 0, 3); plan[s + 10].pin = 3;
    instr(B_LDI, 0, 0, 0); instr(B_ST, 0, 0, 2);
    s = plan.size(); instr(B_BR, 0, 0, 0); plan[s + 6].pin = 4;
    s = plan.size(); instr(B_BR, 1, 0, 0); plan[s + 6].pin = 5;
    instr(B_NOP, 0, 0, 0);
    s = plan.size(); instr(5'b11111, 0, 0, 0); plan[s + 2].pin = 6;
    instr(B_ADD, 0, 0, 0); plan[s + 3].pin = 7;
    instr(5'b10000, 0, 0, 0);
    budget = 8; instr(B_LD, 0, 0, 3); budget = -1;  // cut off mid data-wait
    clr_cycles(1);
    s = plan.size(); instr(B_HALT, 0, 0, 0); halt_cycles(4); plan[s + 3].pin = 8;
    clr_cycles(2);
    s2 = plan.size(); instr(B_AND, 0, 0, 0); plan[s2].pin = 9;

    foreach (plan[i]) begin
      @(negedge clk);
      clr = plan[i].clr; bus.IR_op = plan[i].op;
      bus.CON_FF = plan[i].con; bus.mem_ready = plan[i].mr;
      #1;
      got = dut_vec();
      chk("ctrl_vec", i, 32'(got), 32'(plan[i].e));
      srcs = $countones({bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout,
                         bus.Cout, bus.BAout, bus.Rout});
      chk("bus_src_le1", i, 32'(srcs <= 1), 32'd1);
      if (bus.Read) rd_run++;
      else begin
        if (rd_run != 0) last_run = rd_run;
        rd_run = 0;
      end
      case (plan[i].pin)
        1:  chk("and_T4", i, 32'({bus.Grc, bus.Rout, bus.Zin, bus.ALU_select}), 32'hE5);
        2:  chk("and_fetch0_at6", i, 32'({bus.PCout, bus.MARin, bus.IncPC, bus.Zin}), 32'hF);
        3: begin
          chk("ld_read_len", i, 32'(last_run), 32'd4);
          chk("ld_T7", i, 32'({bus.MDRout, bus.Gra, bus.Rin}), 32'h7);
        end
        4:  chk("br_con0_T6", i, 32'({bus.Zlowout, bus.PCin}), 32'h2);
        5:  chk("br_con1_T6", i, 32'({bus.Zlowout, bus.PCin}), 32'h3);
        6:  chk("illegal_pulse", i, 32'(bus.illegal_op), 32'h1);
        7:  chk("illegal_next", i, 32'({bus.PCout, bus.illegal_op}), 32'h2);
        8:  chk("halt_run", i, 32'({bus.Run, bus.PCout}), 32'h0);
        9:  chk("post_clr_fetch", i, 32'({bus.Run, bus.PCout}), 32'h3);
        10: chk("reset_outputs", i, 32'(got), 32'h2);
        default: ;
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
